axi_sram_slave: RTL and testbench

//   AXI3-style slave (32-bit data, 4-bit len) backed by an internal word-addressed RAM; the responder end of the AXI master port driven by
//   cpu_axi_interface/system_cache. Serves as the memory model for core-level simulation and as small on-chip RAM in FPGA builds.
//   One transaction in flight at a time; read and write address channels are arbitrated round-robin.

---
 rtl/axi_sram_slave_if.sv | 48 ++++
 rtl/axi_sram_slave.sv | 219 +++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_if.sv
// AXI3-style read/write channel bundle between a bus master and axi_sram_slave.
interface axi_sram_slave_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [3:0]      arlen;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [3:0]      awlen;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, araddr, arlen, arburst, arvalid, rready,
    output awid, awaddr, awlen, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  arid, araddr, arlen, arburst, arvalid, rready,
    input  awid, awaddr, awlen, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3-style slave in front of a word-addressed RAM. One burst in flight;
// AR and AW are granted round-robin with the write side winning first.
module axi_sram_slave #(
  parameter int ID_W           = 4,
  parameter int MEM_WORDS_LOG2 = 14
) (
  input logic             clk,
  input logic             rst,
  axi_sram_slave_if.slave bus
);

  localparam int AW = MEM_WORDS_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_WR    = 2'd2,
    ST_WRESP = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            rdy_en_q, wr_prio_q, werr_q;
  logic [ID_W-1:0] id_q, rid_q, bid_q;
  logic [AW-1:0]   idx_q;
  logic [3:0]      len_q;
  logic [1:0]      burst_q, rresp_q, bresp_q;
  logic [4:0]      beat_q;
  logic            rvalid_q, rlast_q, bvalid_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem_q [0:(1<<AW)-1];

  logic arready_s, awready_s, wready_s;
  logic ar_hs_s, aw_hs_s, w_hs_s, r_load_s, r_done_s, b_done_s;
  logic last_beat_s, wlast_bad_s, reserved_s, mem_we_s;

  // Word index of the next beat: FIXED holds, WRAP stays inside its aligned
  // window for legal lengths, everything else increments modulo RAM depth.
  function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx,
                                             input logic [3:0]    len,
                                             input logic [1:0]    burst);
    logic [AW-1:0] inc;
    logic [AW-1:0] mask;
    inc  = idx + {{(AW-1){1'b0}}, 1'b1};
    mask = {{(AW-4){1'b0}}, len};
    case (burst)
      2'b00: next_idx = idx;
      2'b10: begin
        if (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15) begin
          next_idx = (idx & ~mask) | (inc & mask);
        end else begin
          next_idx = inc;
        end
      end
      default: next_idx = inc;
    endcase
  endfunction

  // Next-state decode, channel readies and per-cycle handshake strobes.
  always_comb begin
    state_d     = state_q;
    arready_s   = 1'b0;
    awready_s   = 1'b0;
    wready_s    = 1'b0;
    ar_hs_s     = 1'b0;
    aw_hs_s     = 1'b0;
    w_hs_s      = 1'b0;
    r_load_s    = 1'b0;
    r_done_s    = 1'b0;
    b_done_s    = 1'b0;
    last_beat_s = (beat_q == {1'b0, len_q});
    reserved_s  = (burst_q == 2'b11);
    wlast_bad_s = (bus.wlast != last_beat_s);
    case (state_q)
      ST_IDLE: begin
        if (rdy_en_q) begin
          awready_s = !bus.arvalid || wr_prio_q;
          arready_s = !bus.awvalid || !wr_prio_q;
        end else begin
          awready_s = 1'b0;
          arready_s = 1'b0;
        end
        aw_hs_s = awready_s && bus.awvalid;
        ar_hs_s = arready_s && bus.arvalid;
        if (aw_hs_s) begin
          state_d = ST_WR;
        end else if (ar_hs_s) begin
          state_d = ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        r_done_s = rvalid_q && bus.rready && rlast_q;
        r_load_s = (!rvalid_q || bus.rready) && (beat_q <= {1'b0, len_q});
        if (r_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_WR: begin
        wready_s = 1'b1;
        w_hs_s   = bus.wvalid;
        if (w_hs_s && last_beat_s) begin
          state_d = ST_WRESP;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_WRESP: begin
        b_done_s = bvalid_q && bus.bready;
        if (b_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WRESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    mem_we_s = w_hs_s && !reserved_s && !rst;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst context, beat counting, arbitration priority and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_en_q  <= 1'b0;
      wr_prio_q <= 1'b1;
      werr_q    <= 1'b0;
      id_q      <= {ID_W{1'b0}};
      idx_q     <= {AW{1'b0}};
      len_q     <= 4'd0;
      burst_q   <= 2'b00;
      beat_q    <= 5'd0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
      rid_q     <= {ID_W{1'b0}};
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= {ID_W{1'b0}};
    end else begin
      rdy_en_q <= 1'b1;
      if (aw_hs_s) begin
        id_q      <= bus.awid;
        idx_q     <= bus.awaddr[AW+1:2];
        len_q     <= bus.awlen;
        burst_q   <= bus.awburst;
        beat_q    <= 5'd0;
        werr_q    <= 1'b0;
        wr_prio_q <= 1'b0;
      end else if (ar_hs_s) begin
        id_q      <= bus.arid;
        idx_q     <= bus.araddr[AW+1:2];
        len_q     <= bus.arlen;
        burst_q   <= bus.arburst;
        beat_q    <= 5'd0;
        wr_prio_q <= 1'b1;
      end else if (r_load_s || w_hs_s) begin
        idx_q  <= next_idx(idx_q, len_q, burst_q);
        beat_q <= beat_q + 5'd1;
      end
      if (r_load_s) begin
        rvalid_q <= 1'b1;
        rid_q    <= id_q;
        rdata_q  <= reserved_s ? 32'd0 : mem_q[idx_q];
        rresp_q  <= reserved_s ? 2'b10 : 2'b00;
        rlast_q  <= last_beat_s;
      end else if (rvalid_q && bus.rready) begin
        rvalid_q <= 1'b0;
      end
      if (w_hs_s) begin
        if (wlast_bad_s) begin
          werr_q <= 1'b1;
        end
        if (last_beat_s) begin
          bvalid_q <= 1'b1;
          bid_q    <= id_q;
          bresp_q  <= (reserved_s || werr_q || wlast_bad_s) ? 2'b10 : 2'b00;
        end
      end else if (b_done_s) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Byte-enabled RAM write; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) begin
          mem_q[idx_q][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.arready = arready_s;
  assign bus.awready = awready_s;
  assign bus.wready  = wready_s;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rlast_q;
  assign bus.rid     = rid_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.bid     = bid_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed scoreboard bench for axi_sram_slave.
module tb_axi_sram_slave;

  localparam logic [1:0] B_FIXED = 2'b00;
  localparam logic [1:0] B_INCR  = 2'b01;
  localparam logic [1:0] B_WRAP  = 2'b10;
  localparam logic [1:0] B_RSVD  = 2'b11;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } wbeat_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  rbeat_t rq[$];
  wbeat_t wq[$];
  bexp_t  bq[$];

  axi_sram_slave_if #(.ID_W(4)) bus ();

  axi_sram_slave #(.ID_W(4), .MEM_WORDS_LOG2(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void exp_r(input logic [31:0] d, input logic [1:0] r, input logic l, input logic [3:0] id);
    rq.push_back('{data: d, resp: r, last: l, id: id});
  endfunction

  function automatic void put_w(input logic [31:0] d, input logic [3:0] s, input logic l);
    wq.push_back('{data: d, strb: s, last: l});
  endfunction

  task automatic reset_dut();
    bus.rready = 1'b0;
    bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    #1;
    check("rst_out", {bus.arready, bus.awready, bus.rvalid, bus.wready, bus.bvalid,
                      bus.rid, bus.rdata, bus.rresp, bus.rlast, bus.bid, bus.bresp}, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_rdy", {bus.arready, bus.awready}, 64'd0);
    tick();
  endtask

  task automatic ar_phase(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
    bit hs = 1'b0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arburst = burst;
    bus.arvalid = 1'b1;
    for (int c = 0; c < 50 && !hs; c++) begin
      #1;
      if (bus.arready) hs = 1'b1;
      tick();
    end
    bus.arvalid = 1'b0;
    check("ar_hs", 64'(hs), 64'd1);
  endtask

  task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
    bit hs = 1'b0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awburst = burst;
    bus.awvalid = 1'b1;
    for (int c = 0; c < 50 && !hs; c++) begin
      #1;
      if (bus.awready) hs = 1'b1;
      tick();
    end
    bus.awvalid = 1'b0;
    check("aw_hs", 64'(hs), 64'd1);
  endtask

  // Collect nbeats read beats; toggle drives rready 0,1,0,1... from the first data cycle.
  task automatic r_phase(input int nbeats, input bit toggle);
    int     got = 0;
    int     cyc = 0;
    bit     first = 1'b1;
    bit     held_v = 1'b0;
    bit     rr = 1'b1;
    rbeat_t held;
    rbeat_t e;
    bus.rready = 1'b0;
    #1;
    check("rd_lat0", 64'(bus.rvalid), 64'd0);
    while (got < nbeats && cyc < 200) begin
      tick();
      cyc++;
      rr = toggle ? ~rr : 1'b1;
      bus.rready = rr;
      #1;
      if (first) begin
        check("rd_lat1", 64'(bus.rvalid), 64'd1);
        first = 1'b0;
      end
      if (held_v) begin
        check("r_stable", {bus.rdata, bus.rresp, bus.rlast, bus.rid}, 64'(held));
        held_v = 1'b0;
      end
      if (bus.rvalid && rr) begin
        check("r_expected", 64'(rq.size() > 0), 64'd1);
        if (rq.size() > 0) begin
          e = rq.pop_front();
          check("rdata", 64'(bus.rdata), 64'(e.data));
          check("rresp", 64'(bus.rresp), 64'(e.resp));
          check("rlast", 64'(bus.rlast), 64'(e.last));
          check("rid",   64'(bus.rid),   64'(e.id));
        end
        got++;
      end else if (bus.rvalid) begin
        held = '{data: bus.rdata, resp: bus.rresp, last: bus.rlast, id: bus.rid};
        held_v = 1'b1;
      end
    end
    check("r_beats", 64'(got), 64'(nbeats));
    tick();
    bus.rready = 1'b0;
  endtask

  // Send all queued W beats, then take the response after bdelay stall cycles.
  task automatic w_phase(input int bdelay);
    int     nbeats = wq.size();
    int     sent = 0;
    int     cyc = 0;
    int     held = 0;
    bit     done = 1'b0;
    wbeat_t w;
    bexp_t  e;
    while (sent < nbeats && cyc < 200) begin
      w = wq[0];
      bus.wdata = w.data; bus.wstrb = w.strb; bus.wlast = w.last;
      bus.wvalid = 1'b1;
      #1;
      if (bus.wready) begin
        void'(wq.pop_front());
        sent++;
      end
      tick();
      cyc++;
    end
    bus.wvalid = 1'b0;
    check("w_beats", 64'(sent), 64'(nbeats));
    e = bq.pop_front();
    while (!done && cyc < 400) begin
      bus.bready = (held >= bdelay);
      #1;
      check(bus.bready ? "b_resp" : "b_hold", {bus.bvalid, bus.bid, bus.bresp}, {1'b1, e.id, e.resp});
      if (bus.bready) done = 1'b1;
      else held++;
      tick();
      cyc++;
    end
    bus.bready = 1'b0;
    check("b_done", 64'(done), 64'd1);
  endtask

  initial begin
    string       gtag;
    int          c;
    bit          seen;
    logic [31:0] last_w;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.arid = 4'd0; bus.araddr = 32'd0; bus.arlen = 4'd0; bus.arburst = 2'b00; bus.arvalid = 1'b0;
    bus.awid = 4'd0; bus.awaddr = 32'd0; bus.awlen = 4'd0; bus.awburst = 2'b00; bus.awvalid = 1'b0;
    bus.wdata = 32'd0; bus.wstrb = 4'd0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.rready = 1'b0; bus.bready = 1'b0;
    reset_dut();

    // Full word write and read back.
    put_w(32'hDEADBEEF, 4'hF, 1'b1); bq.push_back('{id: 4'd3, resp: 2'b00});
    aw_phase(4'd3, 32'h100, 4'd0, B_INCR); w_phase(0);
    exp_r(32'hDEADBEEF, 2'b00, 1'b1, 4'd3);
    ar_phase(4'd3, 32'h100, 4'd0, B_INCR); r_phase(1, 1'b0);

    // Partial strobe write.
    put_w(32'h00001234, 4'b0011, 1'b1); bq.push_back('{id: 4'd1, resp: 2'b00});
    aw_phase(4'd1, 32'h100, 4'd0, B_INCR); w_phase(0);
    exp_r(32'hDEAD1234, 2'b00, 1'b1, 4'd1);
    ar_phase(4'd1, 32'h100, 4'd0, B_INCR); r_phase(1, 1'b0);

    // INCR len 3 write with bready held low 5 cycles; INCR read with rready toggling.
    put_w(32'd1, 4'hF, 1'b0); put_w(32'd2, 4'hF, 1'b0); put_w(32'd3, 4'hF, 1'b0); put_w(32'd4, 4'hF, 1'b1);
    bq.push_back('{id: 4'd7, resp: 2'b00});
    aw_phase(4'd7, 32'h200, 4'd3, B_INCR); w_phase(5);
    exp_r(32'd1, 2'b00, 1'b0, 4'd9); exp_r(32'd2, 2'b00, 1'b0, 4'd9);
    exp_r(32'd3, 2'b00, 1'b0, 4'd9); exp_r(32'd4, 2'b00, 1'b1, 4'd9);
    ar_phase(4'd9, 32'h200, 4'd3, B_INCR); r_phase(4, 1'b1);

    // WRAP len 3 starting mid-window.
    exp_r(32'd3, 2'b00, 1'b0, 4'd2); exp_r(32'd4, 2'b00, 1'b0, 4'd2);
    exp_r(32'd1, 2'b00, 1'b0, 4'd2); exp_r(32'd2, 2'b00, 1'b1, 4'd2);
    ar_phase(4'd2, 32'h208, 4'd3, B_WRAP); r_phase(4, 1'b0);

    // FIXED len 2 write leaves the last beat in one word.
    put_w(32'd5, 4'hF, 1'b0); put_w(32'd6, 4'hF, 1'b0); put_w(32'd7, 4'hF, 1'b1);
    bq.push_back('{id: 4'd4, resp: 2'b00});
    aw_phase(4'd4, 32'h300, 4'd2, B_FIXED); w_phase(0);
    exp_r(32'd7, 2'b00, 1'b1, 4'd4);
    ar_phase(4'd4, 32'h300, 4'd0, B_INCR); r_phase(1, 1'b0);

    // Reserved burst: read gives SLVERR and zero data, write is dropped.
    exp_r(32'd0, 2'b10, 1'b1, 4'd8);
    ar_phase(4'd8, 32'h100, 4'd0, B_RSVD); r_phase(1, 1'b0);
    put_w(32'hFFFFFFFF, 4'hF, 1'b1); bq.push_back('{id: 4'd8, resp: 2'b10});
    aw_phase(4'd8, 32'h100, 4'd0, B_RSVD); w_phase(0);
    exp_r(32'hDEAD1234, 2'b00, 1'b1, 4'd8);
    ar_phase(4'd8, 32'h100, 4'd0, B_INCR); r_phase(1, 1'b0);

    // Early wlast: SLVERR but data still lands.
    put_w(32'h11, 4'hF, 1'b1); put_w(32'h22, 4'hF, 1'b1);
    bq.push_back('{id: 4'd5, resp: 2'b10});
    aw_phase(4'd5, 32'h500, 4'd1, B_INCR); w_phase(0);
    exp_r(32'h11, 2'b00, 1'b0, 4'd5); exp_r(32'h22, 2'b00, 1'b1, 4'd5);
    ar_phase(4'd5, 32'h500, 4'd1, B_INCR); r_phase(2, 1'b0);

    // Arbitration: both address channels held valid through reset and four grants.
    bus.arid = 4'd5; bus.araddr = 32'h400; bus.arlen = 4'd0; bus.arburst = B_INCR;
    bus.awid = 4'd6; bus.awaddr = 32'h400; bus.awlen = 4'd0; bus.awburst = B_INCR;
    bus.arvalid = 1'b1; bus.awvalid = 1'b1;
    reset_dut();
    last_w = 32'd0;
    for (int k = 0; k < 4; k++) begin
      gtag = "none";
      c = 0;
      while (gtag == "none" && c < 20) begin
        #1;
        if (bus.arready || bus.awready) begin
          check("grant_excl", 64'(bus.arready & bus.awready), 64'd0);
          gtag = bus.awready ? "W" : "R";
        end else begin
          tick();
        end
        c++;
      end
      check("grant_order", 64'(gtag == ((k % 2 == 0) ? "W" : "R")), 64'd1);
      tick();
      if (gtag == "W") begin
        last_w = 32'hA5A50000 + 32'(k);
        put_w(last_w, 4'hF, 1'b1); bq.push_back('{id: 4'd6, resp: 2'b00});
        w_phase(0);
      end else if (gtag == "R") begin
        exp_r(last_w, 2'b00, 1'b1, 4'd5);
        r_phase(1, 1'b0);
      end
    end
    bus.arvalid = 1'b0; bus.awvalid = 1'b0;
    tick();

    // Reset in the middle of a len 7 read.
    ar_phase(4'd2, 32'h200, 4'd7, B_INCR);
    bus.rready = 1'b1;
    seen = 1'b0;
    c = 0;
    while (!seen && c < 10) begin
      #1;
      if (bus.rvalid) seen = 1'b1;
      else tick();
      c++;
    end
    check("mid_b1", {bus.rvalid, bus.rdata}, {1'b1, 32'd1});
    tick();
    #1;
    check("mid_b2", {bus.rvalid, bus.rdata}, {1'b1, 32'd2});
    rst = 1'b1;
    bus.rready = 1'b0;
    tick();
    #1;
    check("mid_rst", {bus.rvalid, bus.bvalid, bus.wready, bus.arready}, 64'd0);
    rst = 1'b0;
    tick();
    exp_r(32'd1, 2'b00, 1'b1, 4'd3);
    ar_phase(4'd3, 32'h200, 4'd0, B_INCR); r_phase(1, 1'b0);

    check("rq_drained", 64'(rq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
